// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    // Conditional two's-complement absolute value at the widest legal operand
    // size; callers zero-extend the operand, pass its sign condition and
    // truncate the result back to their width. The most-negative value maps
    // to 2^(WIDTH-1) once truncated.
    function automatic logic [63:0] abs_w(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/mult_iter_datapath.sv
// Shift-add datapath: multiplier mp, multiplicand mc and accumulator acc,
// loaded and stepped by the controlling FSM.
module mult_iter_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_mp_init,
    input  logic [WIDTH-1:0]   i_mc_init,
    output logic [2*WIDTH-1:0] o_acc_next,
    output logic [WIDTH-1:0]   o_mp_next
);

    logic [WIDTH-1:0]   r_mp;
    logic [2*WIDTH-1:0] r_mc;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_addend;

    // One add/shift step: add the shifted multiplicand when the current
    // multiplier bit is set.
    always_comb begin
        w_addend   = r_mp[0] ? r_mc : '0;
        o_acc_next = r_acc + w_addend;
        o_mp_next  = r_mp >> 1;
    end

    // Operand registers: load a fresh operation or advance one step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mp  <= '0;
            r_mc  <= '0;
            r_acc <= '0;
        end else if (i_load) begin
            r_mp  <= i_mp_init;
            r_mc  <= {{WIDTH{1'b0}}, i_mc_init};
            r_acc <= '0;
        end else if (i_step) begin
            r_mp  <= o_mp_next;
            r_mc  <= r_mc << 1;
            r_acc <= o_acc_next;
        end
    end

endmodule

// File: rtl/multiplier_iterative_param.sv
// Parametrised iterative multiplier with signed/unsigned mode and
// valid/ready handshakes on both sides.
// Optional early termination when the remaining multiplier bits are all
// zero: define MULT_ITER_EARLY_EXIT_EN.
//
// state | meaning
// IDLE  | ready for a new operation, no result pending
// BUSY  | iterating add/shift steps, inputs ignored
// DONE  | r holds a product, waiting for out_ready
module multiplier_iterative_param
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_in,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] r
);

    localparam int CNT_W = $clog2(WIDTH);

    mult_state_e        r_state;
    mult_state_e        w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_r;

    logic               w_in_ready;
    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic               w_exit;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_mp_next;

    // Operand magnitudes; only taken when the operation is signed.
    always_comb begin
        w_abs_a = WIDTH'(abs_w(64'(a), signed_in & a[WIDTH-1]));
        w_abs_b = WIDTH'(abs_w(64'(b), signed_in & b[WIDTH-1]));
    end

    mult_iter_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_mp_init  (w_abs_a),
        .i_mc_init  (w_abs_b),
        .o_acc_next (w_acc_next),
        .o_mp_next  (w_mp_next)
    );

    // Termination: all WIDTH steps done, or optionally no multiplier bits left.
    always_comb begin
        w_last = (r_cnt == CNT_W'(WIDTH - 1));
`ifdef MULT_ITER_EARLY_EXIT_EN
        w_exit = w_last | (w_mp_next == '0);
`else
        w_exit = w_last;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and control strobes.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                w_step = 1'b1;
                if (w_exit) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_load       = 1'b1;
                        w_state_next = BUSY;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Iteration counter and result sign, captured at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_neg <= 1'b0;
        end else if (w_load) begin
            r_cnt <= '0;
            r_neg <= signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (w_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Result register and valid flag; r stays put after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_r         <= '0;
        end else if (w_step && w_exit) begin
            r_out_valid <= 1'b1;
            r_r         <= r_neg ? -w_acc_next : w_acc_next;
        end else if (r_state == DONE && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign r         = r_r;

endmodule

// File: doc/multiplier_iterative_param.md
# multiplier_iterative_param

Parametrised shift-add iterative multiplier, the successor to the 32-bit unsigned iterative multiplier. It adds a WIDTH parameter, per-operation signed/unsigned mode, and valid/ready handshakes on both input and output. It holds results under backpressure and can optionally terminate early. It sits between the issue logic and the writeback stage as a multi-cycle, one-operation-at-a-time functional unit.

## Interface
- WIDTH, 32, operand width in bits; legal values are 4 to 64.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation offered on a, b, signed_in.
- in_ready  output  1  unit can accept; combinational from state and out_ready.
- signed_in  input  1  1 means a and b are two's complement; 0 means unsigned.
- a  input  WIDTH  multiplier operand.
- b  input  WIDTH  multiplicand operand.
- out_valid  output  1  r holds a completed product.
- out_ready  input  1  consumer takes r.
- r  output  2*WIDTH  product.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch mp = |a|, mc = zero-extended |b|, acc = 0, cnt = 0, neg = signed_in & (a[WIDTH-1] ^ b[WIDTH-1]); go to BUSY.
  - Absolute values apply only when signed_in = 1. The most-negative operand maps to 2^(WIDTH-1) as unsigned.
- BUSY:
  - in_ready = 0.
  - Each cycle: acc += mp[0] ? mc : 0; mp >>= 1; mc <<= 1; cnt += 1.
  - Exit condition: cnt == WIDTH-1 (WIDTH iterations done), or early-exit condition (see Configuration).
  - On exit: r <= neg ? -acc_next : acc_next, out_valid <= 1, go to DONE.
- DONE:
  - out_valid = 1; r is held stable until handshake.
  - in_ready = out_ready.
  - out_ready & in_valid: result consumed and new operation latched in the same edge; go to BUSY.
  - out_ready & !in_valid: go to IDLE, out_valid <= 0.
  - !out_ready: stay in DONE.
- Arithmetic:
  - acc and mc are 2*WIDTH bits; no overflow is possible.
  - Negation is 2*WIDTH-bit two's complement.
  - r keeps its last value after out_valid falls.
- in_valid during BUSY is ignored. The producer must hold its request until in_ready.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, out_valid = 0, r = 0, acc/mp/mc/cnt/neg = 0. in_ready = 1 immediately.
- Reset asserted mid-operation aborts the operation with no output. The first accept is possible on the first edge after rst_n rises.
- Latency, accept edge to out_valid high: WIDTH cycles with early exit compiled out.
- Throughput: one operation per WIDTH+1 cycles with back-to-back accepts in DONE. Stall cycles extend DONE one-for-one.
- No combinational path from in_valid to any output. in_ready depends combinationally on out_ready in DONE only.

## Configuration
- Macro MULT_ITER_EARLY_EXIT_EN.
- Defined:
  - BUSY also exits when mp_next == 0.
  - Iterations = max(1, position of highest set bit of |a| + 1), so latency = that count.
  - a = 0 completes in 1 cycle.
- Undefined:
  - Always WIDTH iterations; fixed latency.
  - Early-exit comparator is absent.

## Structure
- Package mult_pkg holds:
  - state enum mult_state_e {IDLE, BUSY, DONE};
  - helper function abs_w for conditional absolute value.
- Counter width $clog2(WIDTH) is a localparam in the module, not in the package.
- Sub-module mult_iter_datapath holds the registers mp/mc/acc and the single add/shift step. It is controlled by load/step enables from the FSM in the top module.

## Test plan
- WIDTH=32, unsigned, a = b = 0xFFFFFFFF -> r = 0xFFFFFFFE00000001; out_valid exactly 32 cycles after accept (early exit off).
- WIDTH=32, signed:
  - -3 × 5 -> r = 0xFFFFFFFFFFFFFFF1;
  - 0x80000000 × 0x80000000 -> r = 0x4000000000000000;
  - -1 × -1 -> r = 1.
- Backpressure: out_ready low for 10 cycles after out_valid -> r and out_valid stable, in_ready = 0 throughout. Raising out_ready together with in_valid starts the next operation on the same edge.
- Reset mid-operation: rst_n low at cycle 5 of BUSY -> out_valid = 0 and r = 0 immediately. Next operation 7 × 6 gives r = 42.
- MULT_ITER_EARLY_EXIT_EN defined, WIDTH=32:
  - a = 1, b = 0x1234 -> r = 0x1234 after 1 cycle;
  - a = 0 -> r = 0 after 1 cycle;
  - a = 0x80000000, unsigned -> 32 cycles.
- WIDTH=8, random signed and unsigned operands (10k operations) with random out_ready stalls -> every r matches the reference product; no lost or duplicated operations.
